// File: rtl/ul_descrambler.sv
// Uplink descrambler: accepts a block of DATA_DEPTH scrambled words and
// emits them one at a time, XORed with an x^7+x^4+1 keystream.
// LFSR_SEED must be non-zero; an all-zero LFSR never leaves zero.
module ul_descrambler #(
    parameter int         DATA_WIDTH = 8,
    parameter int         DATA_DEPTH = 4,
    parameter logic [6:0] LFSR_SEED  = 7'h7F
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             msg_start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_DEPTH*DATA_WIDTH-1:0] par_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic                             drop
);

    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_DEPTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Advance the LFSR DATA_WIDTH steps; returns {next_state, keystream word}.
    // The first step produces the MSB of the keystream word.
    function automatic logic [DATA_WIDTH+6:0] lfsr_word(input logic [6:0] s);
        logic [6:0]            st;
        logic [DATA_WIDTH-1:0] ks;
        logic                  fb;
        st = s;
        ks = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb    = st[6] ^ st[3];
            ks[i] = fb;
            st    = {st[5:0], fb};
        end
        return {st, ks};
    endfunction

    logic [1:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [6:0]            lfsr;
    logic                  pend;
    logic [DATA_WIDTH-1:0] blk_p1 [DATA_DEPTH];

    logic [DATA_WIDTH+6:0] ks_step;
    logic [DATA_WIDTH-1:0] ks_p1;
    logic [6:0]            lfsr_nxt;
    logic                  vld_p1;

    assign ks_step  = lfsr_word(lfsr);
    assign ks_p1    = ks_step[DATA_WIDTH-1:0];
    assign lfsr_nxt = ks_step[DATA_WIDTH+6:DATA_WIDTH];

    // ---- stage p1: registered block word XOR current keystream ----
    assign vld_p1    = (state == RUN);
    assign out_valid = vld_p1;
    assign out_data  = vld_p1 ? (blk_p1[idx] ^ ks_p1) : '0;
    assign out_last  = vld_p1 && (idx == LAST_IDX);
    assign in_ready  = (state == IDLE);
    assign drop      = in_valid && !in_ready;

    // Control: FSM, word index, LFSR and deferred msg_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            lfsr  <= LFSR_SEED;
            pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Seed load lands on the same edge as a coincident accept,
                    // so that block starts from the seed.
                    if (msg_start) begin
                        lfsr <= LFSR_SEED;
                    end
                    if (in_valid) begin
                        state <= RUN;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    if (msg_start) begin
                        pend <= 1'b1;
                    end
                    if (out_ready) begin
                        lfsr <= lfsr_nxt;
                        idx  <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Apply any msg_start seen while busy on the way back to IDLE.
                    if (pend || msg_start) begin
                        lfsr <= LFSR_SEED;
                    end
                    pend  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data: capture the offered block when it is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                blk_p1[i] <= par_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_ul_descrambler.sv
// Bench for ul_descrambler: directed scenarios plus randomized blocks,
// checked against a keystream-sequence scoreboard.
module tb_ul_descrambler;

    localparam int         DW    = 8;
    localparam int         DD    = 4;
    localparam logic [6:0] SEED  = 7'h7F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          msg_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DD*DW-1:0] par_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          drop;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   ks_pos   = 0;
    bit   seed_pend = 0;
    bit   busy;

    ul_descrambler #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .msg_start(msg_start), .in_valid(in_valid),
        .in_ready(in_ready), .par_in(par_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Keystream word k after a seed load: bit sequence b[n] = b[n-7] ^ b[n-4],
    // with the seed bits (MSB first) as the seven bits preceding b[0].
    function automatic logic [7:0] ks_word_at(input int k);
        bit         h[$];
        bit         b;
        logic [7:0] w;
        for (int i = 6; i >= 0; i--) h.push_back(SEED[i]);
        w = '0;
        for (int n = 0; n < 8 * (k + 1); n++) begin
            b = h[h.size() - 7] ^ h[h.size() - 4];
            h.push_back(b);
            w = {w[6:0], b};
        end
        return w;
    endfunction

    // Scoreboard: observe on the falling edge, inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ks_pos    = 0;
            seed_pend = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 1, 0);
                end else begin
                    check("out_data", {24'h0, out_data}, {24'h0, exp_q[0].d});
                    check("out_last", {31'h0, out_last}, {31'h0, exp_q[0].l});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("last_without_valid", {31'h0, out_last}, 0);
            end
            if (in_valid && in_ready) begin
                if (seed_pend || msg_start) ks_pos = 0;
                seed_pend = 0;
                for (int w = 0; w < DD; w++) begin
                    exp_q.push_back('{d: par_in[w*DW +: DW] ^ ks_word_at(ks_pos), l: (w == DD - 1)});
                    ks_pos++;
                end
            end else if (msg_start) begin
                seed_pend = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; msg_start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_block(input logic [DD*DW-1:0] data, input bit ms);
        int t = 0;
        while (!in_ready && t < 200) begin tick(); t++; end
        if (!in_ready) check("accept_timeout", 0, 1);
        in_valid = 1'b1; par_in = data; msg_start = ms;
        tick();
        in_valid = 1'b0; msg_start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(in_ready && exp_q.size() == 0) && t < 200) begin tick(); t++; end
        if (!(in_ready && exp_q.size() == 0)) check("idle_timeout", 0, 1);
    endtask

    task automatic rand_blocks(input int nblk, input bit rand_ms);
        busy = 1;
        fork
            begin
                for (int b = 0; b < nblk; b++) begin
                    send_block($urandom, rand_ms && ($urandom_range(0, 3) == 0));
                    if (rand_ms && $urandom_range(0, 2) == 0) begin
                        msg_start = 1'b1; tick(); msg_start = 1'b0;
                    end
                end
                wait_idle();
                busy = 0;
            end
            begin
                while (busy) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DD*DW-1:0] pt, scr;
        int               tx_pos;

        // Reset state
        tick();
        do_reset();
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_ready", {31'h0, in_ready}, 1);
        check("rst_data",  {24'h0, out_data}, 0);
        check("rst_last",  {31'h0, out_last}, 0);
        check("rst_drop",  {31'h0, drop}, 0);

        // Known-answer block of zeros after msg_start
        msg_start = 1'b1; tick(); msg_start = 1'b0;
        in_valid = 1'b1; par_in = '0;
        check("pre_accept_valid", {31'h0, out_valid}, 0);
        tick();
        in_valid = 1'b0;
        check("lat_valid", {31'h0, out_valid}, 1);
        check("kat_w0", {24'h0, out_data}, 32'h0E);
        tick();
        check("kat_w1", {24'h0, out_data}, 32'hF2);
        check("kat_last_w1", {31'h0, out_last}, 0);
        tick(); tick();
        check("kat_last_w3", {31'h0, out_last}, 1);
        tick();
        check("done_ready", {31'h0, in_ready}, 0);
        check("done_valid", {31'h0, out_valid}, 0);
        tick();
        check("throughput_ready", {31'h0, in_ready}, 1);

        // Round trip: three blocks scrambled with the same keystream, no msg_start
        do_reset();
        msg_start = 1'b1; tick(); msg_start = 1'b0;
        tx_pos = 0;
        for (int b = 0; b < 3; b++) begin
            pt = $urandom;
            for (int w = 0; w < DD; w++) begin
                scr[w*DW +: DW] = pt[w*DW +: DW] ^ ks_word_at(tx_pos);
                tx_pos++;
            end
            send_block(scr, 0);
            for (int w = 0; w < DD; w++) begin
                check("rt_plain", {24'h0, out_data}, {24'h0, pt[w*DW +: DW]});
                tick();
            end
            wait_idle();
        end

        // Backpressure on word 1
        send_block($urandom, 0);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'h0, out_valid}, 1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();

        // in_valid held through RUN/DONE: drops, then next block after DONE
        in_valid = 1'b1; par_in = $urandom;
        tick();
        par_in = $urandom;
        for (int c = 0; c < DD + 1; c++) begin
            check("drop_busy", {31'h0, drop}, 1);
            tick();
        end
        check("drop_idle", {31'h0, drop}, 0);
        check("ready_after_done", {31'h0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        check("second_accept", {31'h0, out_valid}, 1);
        wait_idle();

        // msg_start during RUN, then zero block restarts the keystream
        send_block($urandom, 0);
        tick();
        msg_start = 1'b1; tick(); msg_start = 1'b0;
        wait_idle();
        send_block('0, 0);
        check("ms_run_restart", {24'h0, out_data}, 32'h0E);
        wait_idle();
        send_block($urandom, 0);
        wait_idle();
        send_block('0, 1);
        check("ms_coincident", {24'h0, out_data}, 32'h0E);
        wait_idle();

        // Reset while word 2 is stalled
        send_block($urandom, 0);
        tick(); tick();
        out_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", {31'h0, out_valid}, 0);
        check("midrst_ready", {31'h0, in_ready}, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        send_block('0, 0);
        check("midrst_restart", {24'h0, out_data}, 32'h0E);
        wait_idle();

        // Randomized blocks with random backpressure and msg_start
        rand_blocks(10, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
